// File: rtl/sine_wave_gen.sv
// Direct digital synthesis sine generator driving an 8-bit offset-binary DAC.
// A phase accumulator advances by fcw once every CLK_DIV clocks. The top two
// phase bits select the quadrant. The next LUT_AW bits index a quarter-wave
// table that is built at elaboration time. Each sample is presented on data
// together with a one-cycle en strobe.
module sine_wave_gen #(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int CLK_DIV = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] fcw,
  output logic [7:0]         data,
  output logic               en,
  output logic               busy
);

  localparam int N     = 1 << LUT_AW;
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [PHASE_W-1:0]   phase;
  logic [DIV_W-1:0]     div_cnt;
  logic [7:0]           data_p1;
  logic                 vld_p1;

  logic                 tick_p0;
  logic [PHASE_W:0]     phase_sum_p0;
  logic                 carry_p0;
  logic                 last_p0;
  logic [1:0]           quad_p0;
  logic [LUT_AW-1:0]    idx_p0;
  logic [LUT_AW-1:0]    addr_p0;
  logic [6:0]           qval_p0;
  logic [7:0]           sample_p0;
  logic [6:0]           qtab [N];

  // Taylor series sine, good to well below one LSB over [0, pi/2].
  function automatic real sin_series(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int i = 1; i < 10; i++) begin
      term = -term * x * x / ((2.0 * i) * (2.0 * i + 1.0));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Quarter-wave entry k, sampled at bin centres, rounded to nearest.
  function automatic int q_entry(input int k);
    real ang;
    ang = (2.0 * k + 1.0) * 3.14159265358979323846 / (4.0 * N);
    return $rtoi(127.0 * sin_series(ang) + 0.5);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_qtab
    localparam logic [6:0] QV = 7'(q_entry(g));
    assign qtab[g] = QV;
  end

  // ---- stage p0: divider tick, phase addition, table lookup ----
  assign tick_p0      = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign phase_sum_p0 = {1'b0, phase} + {1'b0, fcw};
  assign carry_p0     = phase_sum_p0[PHASE_W];
  assign last_p0      = tick_p0 && (state == STOPPING) && (carry_p0 || (fcw == '0));
  assign quad_p0      = phase[PHASE_W-1 -: 2];
  assign idx_p0       = phase[PHASE_W-3 -: LUT_AW];
  // Odd quadrants read the table backwards: N-1-k is the bitwise complement.
  assign addr_p0      = quad_p0[0] ? ~idx_p0 : idx_p0;
  assign qval_p0      = qtab[addr_p0];
  assign sample_p0    = quad_p0[1] ? (8'd128 - {1'b0, qval_p0})
                                   : (8'd128 + {1'b0, qval_p0});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Stop beats start in IDLE; a restart in STOPPING beats the final tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && !stop) state_nxt = RUN;
      RUN:      if (stop)           state_nxt = STOPPING;
      STOPPING: begin
        if (start)        state_nxt = RUN;
        else if (last_p0) state_nxt = IDLE;
      end
      default:            state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state != IDLE);
  end

  // Phase accumulator and sample-rate divider. Both clear on a fresh start only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      div_cnt <= '0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      if (state_nxt == RUN) phase <= '0;
    end else if (tick_p0) begin
      div_cnt <= '0;
      phase   <= phase_sum_p0[PHASE_W-1:0];
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---- stage p1: registered sample and strobe, midscale while idle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= 8'h80;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= tick_p0;
      if (tick_p0)            data_p1 <= sample_p0;
      else if (state == IDLE) data_p1 <= 8'h80;
    end
  end

  assign data = data_p1;
  assign en   = vld_p1;

endmodule

// File: tb/tb_sine_wave_gen.sv
// Self-checking bench for sine_wave_gen with CLK_DIV=4.
module tb_sine_wave_gen;

  localparam int PW = 16;
  localparam int AW = 6;
  localparam int CD = 4;
  localparam int PMOD = 1 << PW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [PW-1:0] fcw   = '0;
  logic [7:0]    data;
  logic          en;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  sine_wave_gen #(.PHASE_W(PW), .LUT_AW(AW), .CLK_DIV(CD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .fcw   (fcw),
    .data  (data),
    .en    (en),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference sample straight from the sine formula for a given phase.
  function automatic int ref_sample(input int ph);
    int  nt;
    int  q;
    int  k;
    int  v;
    real a;
    nt = 1 << AW;
    q  = ph / (1 << (PW - 2));
    k  = (ph % (1 << (PW - 2))) / (1 << (PW - 2 - AW));
    if (q == 1 || q == 3) k = nt - 1 - k;
    a = (2.0 * k + 1.0) * 3.14159265358979323846 / (4.0 * nt);
    v = $rtoi(127.0 * $sin(a) + 0.5);
    return (q < 2) ? 128 + v : 128 - v;
  endfunction

  function automatic int rand_fcw();
    if ($urandom_range(0, 7) == 0) return 0;
    return int'($urandom_range(16'h0400, 16'hFFFF));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance to the next strobe; start/stop are one-cycle pulses.
  task automatic next_strobe(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      gap++;
    end while (en !== 1'b1 && gap < 4 * CD + 4);
  endtask

  task automatic strobe_chk(input string tag, input int exp_gap, input int exp_data);
    int g;
    next_strobe(g);
    check({tag, "_gap"}, g, exp_gap);
    check({tag, "_data"}, data, exp_data);
  endtask

  task automatic do_reset();
    start = 1'b0;
    stop  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [4] = '{130, 255, 126, 1};
    int g;
    int ph;
    int cur;
    int cnt;
    int nrun;
    bit fin;

    // Reset state
    @(negedge clk);
    check("rst_data", data, 8'h80);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Quarter-period steps, first strobe CLK_DIV+1 cycles after start
    do_reset();
    fcw = 16'h4000;
    start = 1'b1;
    strobe_chk("t1_s0", CD + 1, 130);
    check("t1_busy", busy, 1);
    for (int i = 1; i < CD; i++) begin
      @(negedge clk);
      check("t1_hold_en", en, 0);
      check("t1_hold_data", data, 130);
    end
    strobe_chk("t1_s1", 1, 255);
    for (int i = 2; i < 10; i++) strobe_chk("t1_seq", CD, seq[i % 4]);

    // One table step per sample: 130, 133, ... and phase 0x4000 on sample 65
    do_reset();
    fcw = 16'h0100;
    start = 1'b1;
    ph = 0;
    for (int s = 1; s <= 65; s++) begin
      next_strobe(g);
      check("t2_gap", g, (s == 1) ? CD + 1 : CD);
      check("t2_model", data, ref_sample(ph));
      if (s == 1)  check("t2_first", data, 130);
      if (s == 2)  check("t2_second", data, 133);
      if (s == 65) check("t2_s65", data, 255);
      ph = (ph + 16'h0100) % PMOD;
    end

    // Stop after the second strobe: 126 then final 1, then midscale
    do_reset();
    fcw = 16'h4000;
    start = 1'b1;
    strobe_chk("t3_s0", CD + 1, 130);
    strobe_chk("t3_s1", CD, 255);
    stop = 1'b1;
    strobe_chk("t3_s2", CD, 126);
    check("t3_s2_busy", busy, 1);
    strobe_chk("t3_s3", CD, 1);
    check("t3_final_busy", busy, 0);
    @(negedge clk);
    check("t3_mid_data", data, 8'h80);
    check("t3_mid_en", en, 0);
    cnt = 0;
    for (int i = 0; i < 5 * CD; i++) begin
      @(negedge clk);
      if (en === 1'b1) cnt++;
    end
    check("t3_no_en", cnt, 0);

    // Restart while stopping: seamless continuation
    do_reset();
    fcw = 16'h4000;
    start = 1'b1;
    strobe_chk("t4_s0", CD + 1, 130);
    strobe_chk("t4_s1", CD, 255);
    stop = 1'b1;
    strobe_chk("t4_s2", CD, 126);
    start = 1'b1;
    for (int i = 3; i < 8; i++) begin
      strobe_chk("t4_seq", CD, seq[i % 4]);
      check("t4_busy", busy, 1);
    end

    // Asynchronous reset mid-run, no resume afterwards
    do_reset();
    fcw = 16'h2345;
    start = 1'b1;
    strobe_chk("t5_s0", CD + 1, 130);
    next_strobe(g);
    rst_n = 1'b0;
    #1;
    check("t5_async_data", data, 8'h80);
    check("t5_async_en", en, 0);
    check("t5_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5 * CD; i++) begin
      @(negedge clk);
      if (en === 1'b1 || busy === 1'b1) cnt++;
    end
    check("t5_no_resume", cnt, 0);

    // Start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4 * CD; i++) begin
      @(negedge clk);
      if (en === 1'b1 || busy === 1'b1) cnt++;
    end
    start = 1'b0;
    stop  = 1'b0;
    check("t6_idle", cnt, 0);

    // fcw = 0 gives a constant sample, still strobing
    do_reset();
    fcw = '0;
    start = 1'b1;
    strobe_chk("t7_s0", CD + 1, 130);
    for (int i = 0; i < 4; i++) strobe_chk("t7_const", CD, 130);

    // Random fcw, changing mid-run, then stop and drain to the wrap
    for (int r = 0; r < 6; r++) begin
      do_reset();
      cur = rand_fcw();
      fcw = PW'(cur);
      start = 1'b1;
      ph = 0;
      nrun = $urandom_range(2, 6);
      for (int i = 0; i < nrun; i++) begin
        next_strobe(g);
        check("tr_gap", g, (i == 0) ? CD + 1 : CD);
        check("tr_data", data, ref_sample(ph));
        check("tr_busy", busy, 1);
        ph = (ph + cur) % PMOD;
        if ($urandom_range(0, 1) == 1) begin
          cur = rand_fcw();
          fcw = PW'(cur);
        end
      end
      stop = 1'b1;
      for (int i = 0; i < 80; i++) begin
        next_strobe(g);
        check("tr_stop_gap", g, CD);
        check("tr_stop_data", data, ref_sample(ph));
        fin = (ph + cur >= PMOD) || (cur == 0);
        check("tr_stop_busy", busy, fin ? 0 : 1);
        ph = (ph + cur) % PMOD;
        if (fin) break;
      end
      @(negedge clk);
      check("tr_end_data", data, 8'h80);
      check("tr_end_busy", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
